pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program counter and instruction-fetch sequencer. Owns the PC register and
//   the request/response handshake with instruction memory. Presents one
//   instruction at a time to decode. Consumes the branch unit's pc_src and the
//   jump controls to choose the next PC when decode acknowledges the current
//   instruction.
// PARAMETERS
//   XLEN      32            PC/address width
//   RESET_PC  32'h0000_0000 PC loaded on reset
//   TRAP_VEC  32'h0000_0100 PC loaded on misaligned target (MISALIGN_TRAP_EN only)
// PORTS
//   clk            in   1     clock, rising edge
//   rst_n          in   1     asynchronous, active-low reset
//   pc_src         in   1     branch taken, from branch unit; sampled with instr_ack
//   branch_target  in   XLEN  PC + B-imm
//   jump           in   1     JAL/JALR taken; sampled with instr_ack
//   jump_target    in   XLEN  jump destination; bit 0 is cleared internally
//   instr_ack      in   1     decode consumed current instr; ignored unless instr_valid
//   imem_req       out  1     fetch request
//   imem_addr      out  XLEN  fetch address (== pc)
//   imem_ready     in   1     memory accepted request this cycle
//   imem_rvalid    in   1     read data valid
//   imem_rdata     in   32    instruction word
//   instr_valid    out  1     instr/pc valid to decode
//   instr          out  32    fetched instruction (registered)
//   pc             out  XLEN  PC of instr
//   pc_plus4       out  XLEN  pc + 4, modulo 2^XLEN
//   misalign_trap  out  1     one-cycle pulse on misaligned redirect
// BEHAVIOUR
//   Reset (async assert, sync deassert):
//   - pc=RESET_PC, state=IDLE.
//   - imem_req, instr_valid, misalign_trap = 0; instr = 32'h0000_0013 (NOP).
//   FSM: IDLE -> FETCH -> WAIT -> HOLD -> FETCH ...
//   - IDLE: entered only from reset; -> FETCH on the first clock after rst_n high.
//   - FETCH: imem_req=1, imem_addr=pc. imem_ready=1 -> WAIT. Else hold; addr stable.
//   - WAIT: imem_req=0. imem_rvalid=1 -> register imem_rdata into instr, -> HOLD.
//   - HOLD: instr_valid=1; instr/pc held stable until instr_ack.
//   - On instr_ack, load next_pc and go -> FETCH:
//       jump ? {jump_target[XLEN-1:1],1'b0} : pc_src ? branch_target : pc+4.
//   Rules:
//   - jump has priority over pc_src when both are 1.
//   - pc+4 wraps silently: XLEN'hFFFF_FFFC -> 0.
//   - imem_rvalid is ignored in IDLE/FETCH/HOLD. Response is >=1 cycle after accept.
//   - Minimum issue interval: 3 cycles per instruction (FETCH, WAIT, HOLD).
//   - Reset mid-fetch drops imem_req immediately. A late rvalid after reset is
//     discarded because the FSM is in IDLE.
//   - pc_src/jump/targets are don't-care when instr_ack=0.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//   - Redirect target with next_pc[1:0]!=0: pc=TRAP_VEC, misalign_trap=1 for
//     one cycle (the cycle after the ack edge), -> FETCH.
//   MISALIGN_TRAP_EN undefined:
//   - next_pc[1:0] forced to 2'b00; misalign_trap tied 0; TRAP_VEC unused.
// TESTING
//   1. Reset, rst_n high, imem_ready=1, rvalid 1 cycle later with 0x00500093:
//      -> imem_addr=0; instr_valid after 3 clocks; pc=0, instr=0x00500093.
//   2. ack with pc_src=1, branch_target=0x40 -> next imem_addr=0x40.
//      ack with pc_src=0 -> next imem_addr = pc+4.
//   3. ack with jump=1, pc_src=1, jump_target=0x81, branch_target=0x20
//      -> imem_addr=0x80.
//   4. pc=0xFFFF_FFFC, ack, no redirect -> imem_addr=0x0, pc_plus4 was 0x0.
//   5. imem_ready low 5 cycles -> imem_req/addr stable.
//      Assert rst_n=0 during WAIT -> imem_req=0 immediately; stray rvalid
//      after release ignored; fetch restarts at RESET_PC.
//   6. MISALIGN_TRAP_EN: ack with pc_src=1, branch_target=0x42 -> one-cycle
//      misalign_trap, imem_addr=0x100. Undefined: imem_addr=0x40, no trap.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Purpose: PC register and fetch sequencer (IDLE/FETCH/WAIT/HOLD). Optional macro MISALIGN_TRAP_EN traps misaligned redirects.
// Latency: min 3 cycles per instruction (request, response, present); instr registered on imem_rvalid.
// Backpressure: stalls in FETCH while !imem_ready and in WAIT until imem_rvalid; holds instr/pc until instr_ack.
module pc_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_src,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            instr_ack,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misalign_trap
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc_q, pc_nxt;
   logic [XLEN-1:0] next_raw, redirect_pc;
   logic [31:0]     instr_q, instr_nxt;
   logic            ack;

   assign pc_plus4    = pc_q + XLEN'(4);
   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign imem_req    = (state == S_FETCH);
   assign instr_valid = (state == S_HOLD);

   // jump outranks a taken branch; JALR-style bit 0 clear applies to jumps only
   always_comb begin
      if (jump)
         next_raw = {jump_target[XLEN-1:1], 1'b0};
      else if (pc_src)
         next_raw = branch_target;
      else
         next_raw = pc_plus4;
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   logic trap_q;
   logic unused_ok;

   assign misalign      = (next_raw[1:0] != 2'b00);
   assign redirect_pc   = misalign ? TRAP_VEC : next_raw;
   assign misalign_trap = trap_q;
   assign unused_ok     = jump_target[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         trap_q <= 1'b0;
      else
         trap_q <= ack & misalign;
   end
`else
   logic unused_ok;

   assign redirect_pc   = {next_raw[XLEN-1:2], 2'b00};
   assign misalign_trap = 1'b0;
   assign unused_ok     = ^{jump_target[0], next_raw[1:0], TRAP_VEC};
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      ack       = 1'b0;
      case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: if (imem_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            // responses arriving in any other state are stale and dropped
            if (imem_rvalid) begin
               instr_nxt = imem_rdata;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ack) begin
               ack       = 1'b1;
               pc_nxt    = redirect_pc;
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized fetch/redirect traffic against a next-PC model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        instr_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign_trap;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_pc;

   pc_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .pc_src(pc_src), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .instr_ack(instr_ack),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
      .misalign_trap(misalign_trap)
   );

   always #5 clk = ~clk;

   // Next PC straight from the redirect rules, with 32-bit wrap from the logic width.
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic j, input logic b,
                                              input logic [31:0] jt, input logic [31:0] bt,
                                              output logic trap);
      logic [31:0] t;
      if (j)      t = jt - (jt % 2);
      else if (b) t = bt;
      else        t = cur + 32'd4;
`ifdef MISALIGN_TRAP_EN
      trap = (t % 4) != 0;
      if (trap) t = 32'h0000_0100;
`else
      trap = 1'b0;
      t = t - (t % 4);
`endif
      return t;
   endfunction

   // Expects to be entered in or shortly before FETCH; ends at a negedge in HOLD.
   task automatic fetch_one(input int rdy_delay, input int rv_delay, input int hold_cycles,
                            input logic [31:0] word);
      imem_rvalid = 1'b0;
      imem_ready  = 1'b0;
      for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1) begin
         errors++; $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
      end
      checks++;
      if (imem_addr !== exp_pc) begin
         errors++; $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_pc);
      end
      for (int k = 0; k < rdy_delay; k++) begin
         imem_rvalid = 1'($urandom);
         imem_rdata  = $urandom;
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++; $display("FAIL stall_stable: req=%b addr=%h required 1/%h", imem_req, imem_addr, exp_pc);
         end
      end
      imem_rvalid = 1'b0;
      imem_ready  = 1'b1;
      @(posedge clk); #1;
      imem_ready  = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_trap !== 1'b0) begin
         errors++; $display("FAIL wait_outputs: req=%b valid=%b trap=%b required 0/0/0",
                            imem_req, instr_valid, misalign_trap);
      end
      for (int k = 0; k < rv_delay; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL wait_hold: req=%b valid=%b required 0/0", imem_req, instr_valid);
         end
      end
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== word || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
         errors++; $display("FAIL present: valid=%b instr=%h pc=%h pc4=%h required 1/%h/%h/%h",
                            instr_valid, instr, pc, pc_plus4, word, exp_pc, exp_pc + 32'd4);
      end
      for (int k = 0; k < hold_cycles; k++) begin
         instr_ack     = 1'b0;
         pc_src        = 1'($urandom);
         jump          = 1'($urandom);
         branch_target = $urandom;
         jump_target   = $urandom;
         imem_rvalid   = 1'($urandom);
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr !== word || pc !== exp_pc || imem_req !== 1'b0) begin
            errors++; $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b required 1/%h/%h/0",
                               instr_valid, instr, pc, imem_req, word, exp_pc);
         end
      end
      imem_rvalid = 1'b0;
   endtask

   // Entered at a negedge in HOLD; ends at the negedge after the ack edge.
   task automatic ack_one(input logic j, input logic b, input logic [31:0] jt, input logic [31:0] bt);
      logic        exp_trap;
      logic [31:0] nxt;
      nxt = model_next(exp_pc, j, b, jt, bt, exp_trap);
      instr_ack = 1'b1; jump = j; pc_src = b; jump_target = jt; branch_target = bt;
      @(posedge clk); #1;
      instr_ack = 1'b0;
      pc_src = 1'($urandom); jump = 1'($urandom);
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== nxt) begin
         errors++; $display("FAIL redirect: valid=%b req=%b addr=%h required 0/1/%h",
                            instr_valid, imem_req, imem_addr, nxt);
      end
      checks++;
      if (misalign_trap !== exp_trap) begin
         errors++; $display("FAIL trap_pulse: misalign_trap=%b required %b", misalign_trap, exp_trap);
      end
      exp_pc = nxt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pc_src = 0; jump = 0; instr_ack = 0; branch_target = 0; jump_target = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_trap !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: req=%b valid=%b trap=%b required 0/0/0",
                            imem_req, instr_valid, misalign_trap);
      end
      checks++;
      if (instr !== 32'h0000_0013 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
         errors++; $display("FAIL reset_data: instr=%h pc=%h pc4=%h required 00000013/0/4", instr, pc, pc_plus4);
      end
      exp_pc = 32'h0;
   endtask

   task automatic test_first_fetch();
      rst_n = 1'b1;
      imem_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL first_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
      end
      @(posedge clk); #1;
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL first_wait: valid=%b req=%b required 0/0", instr_valid, imem_req);
      end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0050_0093) begin
         errors++; $display("FAIL first_instr: valid=%b pc=%h instr=%h required 1/0/00500093",
                            instr_valid, pc, instr);
      end
   endtask

   task automatic test_branch();
      ack_one(1'b0, 1'b1, 32'h0, 32'h40);
      fetch_one(0, 1, 1, 32'h1111_0001);
      ack_one(1'b0, 1'b0, 32'hdead_beef, 32'h1234_5678);
      fetch_one(1, 0, 0, 32'h1111_0002);
   endtask

   task automatic test_jump_priority();
      ack_one(1'b1, 1'b1, 32'h81, 32'h20);
      fetch_one(0, 0, 2, 32'h2222_0001);
   endtask

   task automatic test_wrap();
      ack_one(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
      fetch_one(0, 0, 0, 32'h3333_0001);
      checks++;
      if (pc_plus4 !== 32'h0) begin
         errors++; $display("FAIL wrap_pc4: pc_plus4=%h required 0", pc_plus4);
      end
      ack_one(1'b0, 1'b0, 32'h0, 32'h0);
      fetch_one(0, 0, 0, 32'h3333_0002);
   endtask

   task automatic test_stall_and_reset();
      ack_one(1'b0, 1'b1, 32'h0, 32'h200);
      fetch_one(5, 2, 0, 32'h4444_0001);
      ack_one(1'b0, 1'b0, 32'h0, 32'h0);
      // reset while requesting drops imem_req without a clock
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc !== 32'h0) begin
         errors++; $display("FAIL reset_in_fetch: req=%b pc=%h required 0/0", imem_req, pc);
      end
      @(negedge clk); rst_n = 1'b1;
      exp_pc = 32'h0;
      fetch_one(0, 0, 0, 32'h4444_0002);
      ack_one(1'b0, 1'b1, 32'h0, 32'h300);
      imem_ready = 1'b1;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013 || pc !== 32'h0) begin
         errors++; $display("FAIL reset_in_wait: req=%b valid=%b instr=%h pc=%h required 0/0/00000013/0",
                            imem_req, instr_valid, instr, pc);
      end
      @(negedge clk);
      rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req !== 1'b1) begin
         errors++; $display("FAIL stray_rvalid: valid=%b instr=%h req=%b required 0/00000013/1",
                            instr_valid, instr, imem_req);
      end
      exp_pc = 32'h0;
      fetch_one(0, 0, 0, 32'h4444_0003);
   endtask

   task automatic test_misalign();
      ack_one(1'b0, 1'b1, 32'h0, 32'h42);
      fetch_one(0, 0, 0, 32'h5555_0001);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         ack_one(1'($urandom), 1'($urandom), $urandom, $urandom);
         fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_branch();
      test_jump_priority();
      test_wrap();
      test_stall_and_reset();
      test_misalign();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
